// File: rtl/seq_divider.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seq_divider                                                              |
// | Unsigned restoring divider, one quotient bit per clock, start/ready.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module seq_divider #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy,
  output logic             ready
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;

  // The partial remainder always stays below the divisor, so only the
  // shifted value needs the extra bit for the trial subtraction.
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_q_next;

  assign w_shift    = {r_rem, r_q[WIDTH-1]};
  assign w_diff     = w_shift - {1'b0, r_d};
  assign w_rem_next = w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
  assign w_q_next   = {r_q[WIDTH-2:0], ~w_diff[WIDTH]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_rem       <= '0;
      r_q         <= '0;
      r_d         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      busy        <= 1'b0;
      ready       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_q     <= dividend;
            r_d     <= divisor;
            r_rem   <= '0;
            r_count <= '0;
            busy    <= 1'b1;
            if (divisor == '0) begin
              r_state     <= S_DONE;
              ready       <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              r_state     <= S_CALC;
              div_by_zero <= 1'b0;
            end
          end
        end
        S_CALC: begin
          r_rem   <= w_rem_next;
          r_q     <= w_q_next;
          r_count <= r_count + 1'b1;
          if (r_count == c_last) begin
            r_state   <= S_DONE;
            ready     <= 1'b1;
            quotient  <= w_q_next;
            remainder <= w_rem_next;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          ready   <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          ready   <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
